// File: rtl/stack_mem_node.sv
// rtl/stack_mem_node.sv - multi-port LIFO stack node with round-robin push/pop arbitration
module stack_mem_node #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 15,
   parameter int NPORT = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         clear,
   input  logic [NPORT-1:0]             push_valid,
   input  logic [NPORT*WIDTH-1:0]       push_data,
   output logic [NPORT-1:0]             push_ready,
   input  logic [NPORT-1:0]             pop_req,
   output logic [NPORT-1:0]             pop_valid,
   output logic [WIDTH-1:0]             pop_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         full
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

   logic [CW-1:0]    count_q, count_d;
   logic [PW-1:0]    prr_q, prr_d, orr_q, orr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             push_go, pop_go;
   logic [PW-1:0]    push_idx, pop_idx;
   logic             wr_en;
   logic [AW-1:0]    wr_addr, top_addr;
   logic [WIDTH-1:0] wr_data;

   assign top_addr = AW'(count_q - 1'b1);

   // A full stack refuses pushes even if a pop frees a slot this cycle.
   always_comb begin : arb
      logic [PW-1:0] j;
      push_ready = '0;
      pop_valid  = '0;
      push_go    = 1'b0;
      pop_go     = 1'b0;
      push_idx   = '0;
      pop_idx    = '0;
      j          = '0;
      if (!clear && count_q != CW'(DEPTH)) begin
         for (int k = 0; k < NPORT; k++) begin
            j = PW'((int'(prr_q) + k) % NPORT);
            if (!push_go && push_valid[j]) begin
               push_go       = 1'b1;
               push_idx      = j;
               push_ready[j] = 1'b1;
            end
         end
      end
      if (!clear && count_q != '0) begin
         for (int k = 0; k < NPORT; k++) begin
            j = PW'((int'(orr_q) + k) % NPORT);
            if (!pop_go && pop_req[j]) begin
               pop_go       = 1'b1;
               pop_idx      = j;
               pop_valid[j] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      count_d = count_q;
      prr_d   = prr_q;
      orr_d   = orr_q;
      wr_en   = 1'b0;
      wr_addr = top_addr;
      wr_data = push_data[int'(push_idx)*WIDTH +: WIDTH];
      if (clear) begin
         count_d = '0;
      end else begin
         // Simultaneous push/pop overwrites the old top after the popper has taken it.
         if (push_go && pop_go) begin
            wr_en = 1'b1;
         end else if (push_go) begin
            wr_en   = 1'b1;
            wr_addr = AW'(count_q);
            count_d = count_q + 1'b1;
         end else if (pop_go) begin
            count_d = count_q - 1'b1;
         end
         if (push_go) prr_d = (push_idx == PW'(NPORT-1)) ? '0 : push_idx + 1'b1;
         if (pop_go)  orr_d = (pop_idx  == PW'(NPORT-1)) ? '0 : pop_idx  + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         prr_q   <= '0;
         orr_q   <= '0;
      end else begin
         count_q <= count_d;
         prr_q   <= prr_d;
         orr_q   <= orr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset) mem_q[wr_addr] <= wr_data;
   end

   assign pop_data = (count_q != '0) ? mem_q[top_addr] : '0;
   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign full     = (count_q == CW'(DEPTH));

endmodule
